// File: rtl/pc_fetch_unit_pkg.sv
// pc_fetch_unit_pkg: shared constants and FSM state type for the fetch sequencer.
package pc_fetch_unit_pkg;
    localparam logic [31:0] EBREAK_INSTR         = 32'h0010_0073;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;
endpackage

// File: rtl/pc_fetch_unit_next.sv
// pc_next_logic: combinational next-PC select with alignment and range checks.
module pc_next_logic #(
    parameter int IMEM_DEPTH = 64
) (
    input  logic [31:0] i_pc,
    input  logic        i_pc_src,
    input  logic        i_jalr_sel,
    input  logic [31:0] i_imm_ext,
    input  logic [31:0] i_alu_result,
    output logic [31:0] o_next_pc,
    output logic [31:0] o_pc_plus4,
    output logic        o_misalign,
    output logic        o_out_of_range
);
    assign o_pc_plus4     = i_pc + 32'd4;
    // JALR clears only bit 0, so a target with bit 1 set is still reported misaligned
    assign o_next_pc      = !i_pc_src ? o_pc_plus4 :
                            i_jalr_sel ? {i_alu_result[31:1], 1'b0} : i_pc + i_imm_ext;
    assign o_misalign     = o_next_pc[1:0] != 2'b00;
    assign o_out_of_range = {2'b00, o_next_pc[31:2]} >= 32'(IMEM_DEPTH);
endmodule

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner for the single-cycle RV32I core with boot, stall, halt, fault and retire count.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int          IMEM_DEPTH   = 64,
    parameter bit          HALT_EBREAK  = 1'b1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] Instr,
    input  logic        PCSrc,
    input  logic        JalrSel,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUResult,
    input  logic        Stall,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        FetchValid,
    output logic        Halted,
    output logic        Fault,
    output logic [31:0] FaultPC,
    output logic [63:0] InstRet
);
    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fault_pc;
    logic [63:0] r_instret;
    logic        r_valid;
    logic        r_halted;
    logic        r_fault;
    logic [31:0] w_next_pc;
    logic        w_misalign;
    logic        w_out_of_range;
    logic        w_ebreak;

    pc_next_logic #(.IMEM_DEPTH(IMEM_DEPTH)) u_next (
        .i_pc           (r_pc),
        .i_pc_src       (PCSrc),
        .i_jalr_sel     (JalrSel),
        .i_imm_ext      (ImmExt),
        .i_alu_result   (ALUResult),
        .o_next_pc      (w_next_pc),
        .o_pc_plus4     (PCPlus4),
        .o_misalign     (w_misalign),
        .o_out_of_range (w_out_of_range)
    );

    assign w_ebreak = HALT_EBREAK && (Instr == EBREAK_INSTR);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_VECTOR;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
            r_fault_pc <= '0;
            r_instret  <= '0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                    r_valid <= 1'b1;
                end
                ST_RUN: if (!Stall) begin
                    // halting and faulting instructions still count as retired
                    r_instret <= r_instret + 64'd1;
                    if (w_ebreak) begin
                        r_state  <= ST_HALT;
                        r_valid  <= 1'b0;
                        r_halted <= 1'b1;
                    end else if (w_misalign || w_out_of_range) begin
                        r_state    <= ST_FAULT;
                        r_valid    <= 1'b0;
                        r_fault    <= 1'b1;
                        r_fault_pc <= w_next_pc;
                    end else begin
                        r_pc <= w_next_pc;
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign PC         = r_pc;
    assign FetchValid = r_valid;
    assign Halted     = r_halted;
    assign Fault      = r_fault;
    assign FaultPC    = r_fault_pc;
    assign InstRet    = r_instret;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized run against a behavioural fetch model.
module tb_pc_fetch_unit;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] Instr = '0;
    logic        PCSrc = 1'b0;
    logic        JalrSel = 1'b0;
    logic [31:0] ImmExt = '0;
    logic [31:0] ALUResult = '0;
    logic        Stall = 1'b0;
    logic [31:0] PC, PCPlus4, FaultPC;
    logic        FetchValid, Halted, Fault;
    logic [63:0] InstRet;

    int checks = 0;
    int errors = 0;

    // model: 0 boot, 1 run, 2 halted, 3 faulted
    int          m_mode;
    logic [31:0] m_pc, m_fpc;
    logic [63:0] m_ir;

    pc_fetch_unit dut (
        .CLK(CLK), .RST(RST), .Instr(Instr), .PCSrc(PCSrc), .JalrSel(JalrSel),
        .ImmExt(ImmExt), .ALUResult(ALUResult), .Stall(Stall), .PC(PC), .PCPlus4(PCPlus4),
        .FetchValid(FetchValid), .Halted(Halted), .Fault(Fault), .FaultPC(FaultPC), .InstRet(InstRet)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 32'h0;
        m_fpc  = 32'h0;
        m_ir   = 64'd0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        Stall = 1'b0; PCSrc = 1'b0; JalrSel = 1'b0; Instr = '0;
        model_reset();
        #2;
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic step(input bit st, input bit src, input bit js, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] ins);
        logic [31:0] tgt;
        Stall = st; PCSrc = src; JalrSel = js; ImmExt = imm; ALUResult = alu; Instr = ins;
        if (m_mode == 0) m_mode = 1;
        else if (m_mode == 1 && !st) begin
            tgt = !src ? m_pc + 4 : (!js ? m_pc + imm : alu & 32'hFFFF_FFFE);
            m_ir = m_ir + 1;
            if (ins == 32'h0010_0073) m_mode = 2;
            else if (tgt % 4 != 0 || tgt / 4 >= 64) begin m_mode = 3; m_fpc = tgt; end
            else m_pc = tgt;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (PC !== 32'h0 || FetchValid !== 1'b0 || InstRet !== 64'd0 || Fault !== 1'b0 || Halted !== 1'b0) begin
            errors++; $display("FAIL reset_state PC=%h FV=%b IR=%0d F=%b H=%b exp 0/0/0/0/0", PC, FetchValid, InstRet, Fault, Halted);
        end
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
        #1;
        checks++; if (FetchValid !== 1'b0 || PC !== 32'h0) begin
            errors++; $display("FAIL boot_cycle FV=%b PC=%h exp 0/00000000", FetchValid, PC);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (FetchValid !== 1'b1 || PC !== 32'h0 || InstRet !== 64'd0) begin
            errors++; $display("FAIL first_run FV=%b PC=%h IR=%0d exp 1/00000000/0", FetchValid, PC, InstRet);
        end
        checks++; if (PCPlus4 !== 32'h4) begin
            errors++; $display("FAIL pcplus4 got=%h exp=00000004", PCPlus4);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h4 || InstRet !== 64'd1) begin
            errors++; $display("FAIL seq_1 PC=%h IR=%0d exp 00000004/1", PC, InstRet);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h8 || InstRet !== 64'd2) begin
            errors++; $display("FAIL seq_2 PC=%h IR=%0d exp 00000008/2", PC, InstRet);
        end
    endtask

    task automatic test_branch();
        step(0, 1, 0, 32'hFFFF_FFF8, 0, 0);
        checks++; if (PC !== 32'h0 || InstRet !== 64'd3) begin
            errors++; $display("FAIL branch_back PC=%h IR=%0d exp 00000000/3", PC, InstRet);
        end
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h10, 0, 0);
        checks++; if (PC !== 32'h18 || InstRet !== 64'd6) begin
            errors++; $display("FAIL branch_fwd PC=%h IR=%0d exp 00000018/6", PC, InstRet);
        end
    endtask

    task automatic test_jalr();
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 1, 32'h5555, 32'h21, 0);
        checks++; if (PC !== 32'h20 || InstRet !== 64'd2) begin
            errors++; $display("FAIL jalr_bit0 PC=%h IR=%0d exp 00000020/2", PC, InstRet);
        end
        step(0, 1, 0, 32'hFFFF_FFE4, 0, 0);
        step(0, 1, 1, 0, 32'h22, 0);
        checks++; if (Fault !== 1'b1 || FaultPC !== 32'h22 || PC !== 32'h4 || InstRet !== 64'd4 || FetchValid !== 1'b0) begin
            errors++; $display("FAIL jalr_misalign F=%b FPC=%h PC=%h IR=%0d FV=%b exp 1/00000022/00000004/4/0", Fault, FaultPC, PC, InstRet, FetchValid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 32'h40, 0, 32'h0010_0073);
            checks++; if (PC !== 32'hC || InstRet !== 64'd3 || FetchValid !== 1'b1 || Halted !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d] PC=%h IR=%0d FV=%b H=%b exp 0000000c/3/1/0", i, PC, InstRet, FetchValid, Halted);
            end
        end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (PC !== 32'h10 || InstRet !== 64'd4) begin
            errors++; $display("FAIL stall_release PC=%h IR=%0d exp 00000010/4", PC, InstRet);
        end
    endtask

    task automatic test_ebreak();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'h40, 0, 32'h0010_0073);
        checks++; if (Halted !== 1'b1 || PC !== 32'h14 || FetchValid !== 1'b0 || InstRet !== 64'd6 || Fault !== 1'b0) begin
            errors++; $display("FAIL ebreak H=%b PC=%h FV=%b IR=%0d F=%b exp 1/00000014/0/6/0", Halted, PC, FetchValid, InstRet, Fault);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h8, 0, 0);
        checks++; if (Halted !== 1'b1 || PC !== 32'h14 || InstRet !== 64'd6) begin
            errors++; $display("FAIL halt_sticky H=%b PC=%h IR=%0d exp 1/00000014/6", Halted, PC, InstRet);
        end
    endtask

    task automatic test_end_fault();
        do_reset();
        step(0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 32'hFC, 0, 0);
        checks++; if (PC !== 32'hFC || Fault !== 1'b0) begin
            errors++; $display("FAIL last_word PC=%h F=%b exp 000000fc/0", PC, Fault);
        end
        step(0, 0, 0, 0, 0, 0);
        checks++; if (Fault !== 1'b1 || FaultPC !== 32'h100 || PC !== 32'hFC || InstRet !== 64'd2) begin
            errors++; $display("FAIL end_wrap F=%b FPC=%h PC=%h IR=%0d exp 1/00000100/000000fc/2", Fault, FaultPC, PC, InstRet);
        end
        #2;
        RST = 1'b0;
        #1;
        checks++; if (PC !== 32'h0 || Fault !== 1'b0 || InstRet !== 64'd0 || FaultPC !== 32'h0 || FetchValid !== 1'b0) begin
            errors++; $display("FAIL async_reset PC=%h F=%b IR=%0d FPC=%h FV=%b exp 0/0/0/0/0", PC, Fault, InstRet, FaultPC, FetchValid);
        end
        model_reset();
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] tgt;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if (m_mode >= 2 && $urandom_range(0, 7) == 0) do_reset();
            tgt = 32'($urandom_range(0, 69)) * 4 + (($urandom_range(0, 9) == 0) ? 32'd2 : 32'd0);
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                 tgt - m_pc, tgt | 32'($urandom_range(0, 1)),
                 ($urandom_range(0, 24) == 0) ? 32'h0010_0073 : $urandom);
            checks++; if (PC !== m_pc || InstRet !== m_ir || FetchValid !== (m_mode == 1) || Halted !== (m_mode == 2)
                          || Fault !== (m_mode == 3) || FaultPC !== m_fpc || PCPlus4 !== m_pc + 32'd4) begin
                errors++; $display("FAIL random[%0d] PC=%h/%h IR=%0d/%0d FV=%b H=%b F=%b FPC=%h/%h mode=%0d",
                                   n, PC, m_pc, InstRet, m_ir, FetchValid, Halted, Fault, FaultPC, m_fpc, m_mode);
            end
        end
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jalr();
        test_stall();
        test_ebreak();
        test_end_fault();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
